yutorina_bus_arbiter: RTL and testbench
=======================================

YUTORINA_BUS_ARBITER -- requirements
Module: yutorina_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, 30, word-address width.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter TIMEOUT, 255, max cycles a transfer waits for bus_ack (1..2^8-1).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  pipeline flush from control unit.
REQ-007 if_req / if_addr  in  1 / ADDR_W  instruction-fetch read request and word address.
REQ-008 if_rdata / if_busy  out  DATA_W / 1  fetch data, fetch stall.
REQ-009 mem_req / mem_rw / mem_addr / mem_wdata  in  1 / 1 / ADDR_W / DATA_W  data request; mem_rw=1 write, 0 read.
REQ-010 mem_rdata / mem_busy  out  DATA_W / 1  load data, data stall.
REQ-011 bus_req / bus_rw / bus_addr / bus_wdata  out  1 / 1 / ADDR_W / DATA_W  shared memory-port request.
REQ-012 bus_rdata / bus_ack  in  DATA_W / 1  port read data, transfer-complete strobe.
REQ-013 bus_err  out  1  one-cycle timeout pulse.

Function
REQ-014 FSM states SHALL be IDLE, IF_XFER, MEM_XFER, IF_DONE, MEM_DONE.
REQ-015 IDLE: mem_req=1 -> MEM_XFER unless last_grant=MEM and if_req=1 & flush=0, then IF_XFER; else if_req=1 & flush=0 -> IF_XFER; else stay.
REQ-016 last_grant SHALL be a 1-bit register updated on every grant (MEM or IF), giving strict alternation when both requests pend.
REQ-017 On grant, address, rw and wdata of the winner SHALL be latched; bus_addr/bus_rw/bus_wdata SHALL drive the latched values, not live inputs.
REQ-018 bus_req SHALL be 1 exactly in IF_XFER and MEM_XFER; bus_rw SHALL be 0 in IF_XFER.
REQ-019 XFER with bus_ack=1 -> matching DONE; bus_rdata latched into if_rdata (IF) or mem_rdata (MEM read); mem_rdata unchanged on writes.
REQ-020 DONE SHALL last exactly one cycle, then IDLE.
REQ-021 if_busy = if_req & (state != IF_DONE); mem_busy = mem_req & (state != MEM_DONE); both combinational.
REQ-022 Latency: request first seen in IDLE at cycle N -> bus_req from N+1; ack at cycle M -> busy low at M+1, rdata valid at M+1; minimum N..N+2 for zero-wait bus.
REQ-023 Wait counter (8 bit) SHALL clear on entering XFER and increment each XFER cycle without ack; at count=TIMEOUT without ack -> DONE, bus_err=1 for that cycle, rdata register loaded with 0.
REQ-024 bus_ack in the same cycle as count=TIMEOUT SHALL count as success (no bus_err, bus_rdata latched).
REQ-025 flush SHALL NOT abort an XFER in progress; it only blocks new IF grants while high.
REQ-026 bus_ack outside XFER SHALL be ignored.
REQ-027 Requester dropping req during XFER SHALL NOT abort the transfer; its DONE data is still latched.
REQ-028 if_rdata/mem_rdata SHALL hold their value until the next completion for that requester.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, last_grant=IF, counter 0, if_rdata=0, mem_rdata=0, latched addr/wdata/rw=0, bus_err=0, from any state including mid-XFER (bus_req drops next cycle).
REQ-030 Outputs SHALL be bus_req=0, bus_err=0 during reset; busy outputs follow REQ-021 with state IDLE.

Verification
REQ-031 Fetch only: if_req=1, if_addr=0x10, ack on 2nd XFER cycle with bus_rdata=0xDEADBEEF -> bus_addr=0x10, bus_rw=0, if_busy low one cycle with if_rdata=0xDEADBEEF.
REQ-032 Simultaneous if_req & mem_req (read 0x20) from reset -> MEM granted first (last_grant=IF), then IF; both completed, no bus_err.
REQ-033 Store: mem_req=1, mem_rw=1, mem_addr=0x40, mem_wdata=0x12345678, inputs changed after grant -> bus_wdata/addr stay 0x12345678/0x40 until ack; mem_rdata unchanged.
REQ-034 No ack, TIMEOUT=4 -> bus_req high 4 cycles, bus_err=1 one cycle, mem_busy low one cycle, mem_rdata=0.
REQ-035 flush=1 with if_req=1 in IDLE -> no grant; flush during IF_XFER -> transfer completes normally.
REQ-036 rst=1 mid-MEM_XFER -> next cycle IDLE, bus_req=0, rdata registers 0; subsequent request served normally.

Source files
------------

// File: rtl/yutorina_bus_arbiter_if.sv
// Bundle between the arbiter, its two requesters and the shared
// memory port; master = core/memory side, slave = arbiter side.
interface yutorina_bus_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              flush;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_busy;
   logic              mem_req;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_busy;
   logic              bus_req;
   logic              bus_rw;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;
   logic              bus_err;

   modport master (
      output flush, if_req, if_addr,
      output mem_req, mem_rw, mem_addr, mem_wdata,
      output bus_rdata, bus_ack,
      input  if_rdata, if_busy, mem_rdata, mem_busy,
      input  bus_req, bus_rw, bus_addr, bus_wdata, bus_err
   );

   modport slave (
      input  flush, if_req, if_addr,
      input  mem_req, mem_rw, mem_addr, mem_wdata,
      input  bus_rdata, bus_ack,
      output if_rdata, if_busy, mem_rdata, mem_busy,
      output bus_req, bus_rw, bus_addr, bus_wdata, bus_err
   );
endinterface

// File: rtl/yutorina_bus_arbiter.sv
// Fetch/data arbiter for one shared memory port: alternating
// grants, latched request, bounded wait with timeout pulse.
module yutorina_bus_arbiter #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic                   clk,
   input logic                   rst,
   yutorina_bus_arbiter_if.slave arb
);

   typedef enum logic [2:0] {
      IDLE,
      IF_XFER,
      MEM_XFER,
      IF_DONE,
      MEM_DONE
   } state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t            state;
   state_t            state_nx;
   logic              last_mem;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] mem_rdata_q;
   logic              err_q;

   logic xfer;
   logic if_ok;
   logic expire;
   logic finish;
   logic grant_if;
   logic grant_mem;

   assign xfer   = (state == IF_XFER) || (state == MEM_XFER);
   assign if_ok  = arb.if_req && !arb.flush;
   // ack on the final allowed cycle wins over the timeout
   assign expire = xfer && !arb.bus_ack && (cnt == LAST_WAIT);
   assign finish = xfer && (arb.bus_ack || expire);

   always_comb begin
      state_nx  = state;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb.mem_req && !(last_mem && if_ok)) begin
               state_nx  = MEM_XFER;
               grant_mem = 1'b1;
            end else if (if_ok) begin
               state_nx = IF_XFER;
               grant_if = 1'b1;
            end
         end
         IF_XFER:  if (finish) state_nx = IF_DONE;
         MEM_XFER: if (finish) state_nx = MEM_DONE;
         IF_DONE:  state_nx = IDLE;
         MEM_DONE: state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_mem    <= 1'b0;
         cnt         <= '0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state <= state_nx;
         err_q <= expire;
         if (grant_mem) begin
            last_mem <= 1'b1;
            addr_q   <= arb.mem_addr;
            rw_q     <= arb.mem_rw;
            wdata_q  <= arb.mem_wdata;
         end else if (grant_if) begin
            last_mem <= 1'b0;
            addr_q   <= arb.if_addr;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
         end
         if (grant_if || grant_mem) begin
            cnt <= '0;
         end else if (xfer && !arb.bus_ack) begin
            cnt <= cnt + 8'd1;
         end
         if (finish && state == IF_XFER) begin
            if_rdata_q <= expire ? '0 : arb.bus_rdata;
         end
         // stores never disturb the load data register
         if (finish && state == MEM_XFER && !rw_q) begin
            mem_rdata_q <= expire ? '0 : arb.bus_rdata;
         end
      end
   end

   assign arb.bus_req   = xfer && !rst;
   assign arb.bus_err   = err_q && !rst;
   assign arb.bus_rw    = rw_q;
   assign arb.bus_addr  = addr_q;
   assign arb.bus_wdata = wdata_q;
   assign arb.if_rdata  = if_rdata_q;
   assign arb.mem_rdata = mem_rdata_q;
   assign arb.if_busy   = arb.if_req && (state != IF_DONE);
   assign arb.mem_busy  = arb.mem_req && (state != MEM_DONE);

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Random and directed bench for yutorina_bus_arbiter against a
// transaction-level reference model.
module tb_yutorina_bus_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   yutorina_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) intf ();

   yutorina_bus_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .arb(intf.slave)
   );

   always #5 clk = ~clk;

   // reference model: who owns the port, who is in its done cycle
   int          m_who;
   int          m_done;
   int          m_wait;
   bit          m_err;
   bit          m_last_mem;
   logic [AW-1:0] m_addr;
   bit          m_rw;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_if_rd;
   logic [DW-1:0] m_mem_rd;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_who      = 0;
      m_done     = 0;
      m_wait     = 0;
      m_err      = 1'b0;
      m_last_mem = 1'b0;
      m_addr     = '0;
      m_rw       = 1'b0;
      m_wdata    = '0;
      m_if_rd    = '0;
      m_mem_rd   = '0;
   endtask

   task automatic deliver(input int who,
                          input logic [DW-1:0] d,
                          input bit e);
      m_done = who;
      m_err  = e;
      m_who  = 0;
      if (who == 1) m_if_rd = d;
      else if (!m_rw) m_mem_rd = d;
   endtask

   task automatic model_step();
      int  pw;
      int  pd;
      bit  ok_if;
      if (rst) begin
         model_reset();
         return;
      end
      pw     = m_who;
      pd     = m_done;
      m_done = 0;
      m_err  = 1'b0;
      if (pw != 0) begin
         if (intf.bus_ack) deliver(pw, intf.bus_rdata, 1'b0);
         else if (m_wait + 1 == TO) deliver(pw, '0, 1'b1);
         else m_wait++;
      end else if (pd == 0) begin
         ok_if = intf.if_req && !intf.flush;
         if (intf.mem_req && !(m_last_mem && ok_if)) begin
            m_who      = 2;
            m_wait     = 0;
            m_last_mem = 1'b1;
            m_addr     = intf.mem_addr;
            m_rw       = intf.mem_rw;
            m_wdata    = intf.mem_wdata;
         end else if (ok_if) begin
            m_who      = 1;
            m_wait     = 0;
            m_last_mem = 1'b0;
            m_addr     = intf.if_addr;
            m_rw       = 1'b0;
            m_wdata    = '0;
         end
      end
   endtask

   task automatic compare();
      bit req_e;
      req_e = (m_who != 0) && !rst;
      chk("bus_req", 32'(intf.bus_req), 32'(req_e));
      chk("bus_err", 32'(intf.bus_err), 32'(m_err && !rst));
      chk("if_busy", 32'(intf.if_busy),
          32'(intf.if_req && m_done != 1));
      chk("mem_busy", 32'(intf.mem_busy),
          32'(intf.mem_req && m_done != 2));
      chk("if_rdata", intf.if_rdata, m_if_rd);
      chk("mem_rdata", intf.mem_rdata, m_mem_rd);
      if (req_e) begin
         chk("bus_addr", 32'(intf.bus_addr), 32'(m_addr));
         chk("bus_rw", 32'(intf.bus_rw), 32'(m_rw));
         chk("bus_wdata", intf.bus_wdata, m_wdata);
      end
   endtask

   task automatic tick(input logic r, input logic fl,
                       input logic ir, input logic [AW-1:0] ia,
                       input logic mr, input logic mw,
                       input logic [AW-1:0] ma,
                       input logic [DW-1:0] mwd,
                       input logic ba, input logic [DW-1:0] brd);
      @(negedge clk);
      rst            = r;
      intf.flush     = fl;
      intf.if_req    = ir;
      intf.if_addr   = ia;
      intf.mem_req   = mr;
      intf.mem_rw    = mw;
      intf.mem_addr  = ma;
      intf.mem_wdata = mwd;
      intf.bus_ack   = ba;
      intf.bus_rdata = brd;
      #1;
      compare();
      @(posedge clk);
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         tick(0, 0, 0, '0, 0, 0, '0, '0, 0, '0);
   endtask

   initial begin
      intf.flush     = 1'b0;
      intf.if_req    = 1'b0;
      intf.if_addr   = '0;
      intf.mem_req   = 1'b0;
      intf.mem_rw    = 1'b0;
      intf.mem_addr  = '0;
      intf.mem_wdata = '0;
      intf.bus_ack   = 1'b0;
      intf.bus_rdata = '0;
      model_reset();

      tick(1, 0, 0, '0, 0, 0, '0, '0, 1, 32'h1111);
      tick(1, 0, 1, 30'h5, 1, 0, 30'h6, '0, 0, '0);
      #1;
      chk("rst_bus_req", 32'(intf.bus_req), 0);
      chk("rst_if_rdata", intf.if_rdata, 0);

      // fetch with ack on second transfer cycle
      tick(0, 0, 1, 30'h10, 0, 0, '0, '0, 0, '0);
      #1;
      chk("f_bus_req", 32'(intf.bus_req), 1);
      chk("f_bus_addr", 32'(intf.bus_addr), 32'h10);
      chk("f_bus_rw", 32'(intf.bus_rw), 0);
      tick(0, 0, 1, 30'h10, 0, 0, '0, '0, 0, '0);
      tick(0, 0, 1, 30'h10, 0, 0, '0, '0, 1, 32'hDEADBEEF);
      #1;
      chk("f_if_busy", 32'(intf.if_busy), 0);
      chk("f_if_rdata", intf.if_rdata, 32'hDEADBEEF);
      tick(0, 0, 0, '0, 0, 0, '0, '0, 0, '0);

      // both pending straight out of reset: data side first
      tick(1, 0, 0, '0, 0, 0, '0, '0, 0, '0);
      tick(0, 0, 1, 30'h30, 1, 0, 30'h20, '0, 0, '0);
      #1;
      chk("s_first_addr", 32'(intf.bus_addr), 32'h20);
      tick(0, 0, 1, 30'h30, 1, 0, 30'h20, '0, 1, 32'hCAFE0001);
      tick(0, 0, 1, 30'h30, 0, 0, '0, '0, 0, '0);
      tick(0, 0, 1, 30'h30, 0, 0, '0, '0, 0, '0);
      #1;
      chk("s_second_addr", 32'(intf.bus_addr), 32'h30);
      tick(0, 0, 1, 30'h30, 0, 0, '0, '0, 1, 32'h0BADF00D);
      tick(0, 0, 0, '0, 0, 0, '0, '0, 0, '0);
      chk("s_mem_rdata", intf.mem_rdata, 32'hCAFE0001);
      chk("s_if_rdata", intf.if_rdata, 32'h0BADF00D);

      // store with inputs changing after grant
      tick(0, 0, 0, '0, 1, 1, 30'h40, 32'h12345678, 0, '0);
      for (int i = 0; i < 2; i++) begin
         tick(0, 0, 0, '0, 1, 0, 30'h99, '0, 0, '0);
         chk("st_wdata", intf.bus_wdata, 32'h12345678);
         chk("st_addr", 32'(intf.bus_addr), 32'h40);
      end
      tick(0, 0, 0, '0, 1, 0, 30'h99, '0, 1, 32'h77777777);
      #1;
      chk("st_mem_rdata", intf.mem_rdata, 32'hCAFE0001);
      tick(0, 0, 0, '0, 0, 0, '0, '0, 0, '0);

      // load that never sees an ack
      tick(0, 0, 0, '0, 1, 0, 30'h50, '0, 0, '0);
      for (int i = 0; i < TO; i++) begin
         #1;
         chk("to_bus_req", 32'(intf.bus_req), 1);
         tick(0, 0, 0, '0, 1, 0, 30'h50, '0, 0, '0);
      end
      #1;
      chk("to_bus_req_end", 32'(intf.bus_req), 0);
      chk("to_bus_err", 32'(intf.bus_err), 1);
      chk("to_mem_busy", 32'(intf.mem_busy), 0);
      chk("to_mem_rdata", intf.mem_rdata, 0);
      idle(2);

      // flush blocks new fetch grants but not a running one
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 1, 30'h60, 0, 0, '0, '0, 0, '0);
         chk("fl_no_grant", 32'(intf.bus_req), 0);
      end
      tick(0, 0, 1, 30'h60, 0, 0, '0, '0, 0, '0);
      tick(0, 1, 1, 30'h60, 0, 0, '0, '0, 1, 32'h600D600D);
      #1;
      chk("fl_if_rdata", intf.if_rdata, 32'h600D600D);
      chk("fl_bus_err", 32'(intf.bus_err), 0);
      idle(2);

      // reset in the middle of a data transfer
      tick(0, 0, 0, '0, 1, 0, 30'h70, '0, 0, '0);
      tick(0, 0, 0, '0, 1, 0, 30'h70, '0, 0, '0);
      tick(1, 0, 0, '0, 1, 0, 30'h70, '0, 0, '0);
      #1;
      chk("mr_bus_req", 32'(intf.bus_req), 0);
      chk("mr_if_rdata", intf.if_rdata, 0);
      chk("mr_mem_rdata", intf.mem_rdata, 0);
      tick(0, 0, 0, '0, 1, 0, 30'h74, '0, 0, '0);
      tick(0, 0, 0, '0, 1, 0, 30'h74, '0, 1, 32'hA5A5A5A5);
      #1;
      chk("mr_after", intf.mem_rdata, 32'hA5A5A5A5);
      idle(1);

      // randomized traffic, including stray acks and resets
      for (int i = 0; i < 4000; i++) begin
         tick(($urandom_range(99) < 2),
              ($urandom_range(99) < 15),
              ($urandom_range(99) < 60),
              AW'($urandom),
              ($urandom_range(99) < 50),
              1'($urandom),
              AW'($urandom),
              $urandom,
              ($urandom_range(99) < 35),
              $urandom);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
